fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter in front of the 16-bit FIFO's write side (din_a / wen_a / full).
- Shares the single FIFO write port among NUM_REQ requesters, all in the clk_a domain.
- Grants bursts of up to MAX_BURST words per owner, then rotates priority.
- Never issues a write while full is high, so the FIFO cannot overflow.

---
 rtl/fifo_pkg.sv | 43 ++++
 rtl/fifo_wr_arbiter_rr_pick_comb.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO write-side logic.
//   FIFO_DATA_W : FIFO data width (din_a)
//   MAX_REQ     : largest requester count the round-robin picker supports
//   arb_state_t : write-arbiter state encoding
//   pick_t      : picker result (valid flag + winning index)
//   rr_pick()   : round-robin priority scan starting at a pointer
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_W = 16;
    localparam int MAX_REQ     = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // First requester at or after ptr (wrapping modulo num_req) with its
    // request bit set. Bits at or above num_req must be zero.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input int                 num_req);
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (int'(ptr) + k) % num_req;
            if (k < num_req && !r.valid && req[3'(j)]) begin
                r.valid = 1'b1;
                r.idx   = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick_comb.sv
// ---------------------------------------------------------------------------
// rr_pick_comb
// Pure combinational round-robin priority picker.
//   req   : request vector, one bit per requester
//   ptr   : index that has highest priority this cycle
//   idx   : index of the winning requester (valid only when valid=1)
//   valid : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick_comb
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    pick_t pick;

    // NOTE: every variable written in always_comb gets a value on every
    // path (here by a single unconditional assignment), so no latch is built.
    always_comb begin
        pick = rr_pick(MAX_REQ'(req), 3'(ptr), NUM_REQ);
    end

    assign valid = pick.valid;
    assign idx   = PTR_W'(pick.idx);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the FIFO write port (din_a/wen_a/full) among
// NUM_REQ requesters. An owner keeps the port for up to MAX_BURST words,
// then priority rotates to the next index. No write is issued while full.
//   clk_a    : write-domain clock
//   rst_n    : asynchronous active-low reset
//   req      : per-requester request, held until the word is acked
//   req_data : packed words, requester i at [i*DATA_W +: DATA_W]
//   full     : FIFO full flag
//   din_a    : write data (0 when no write)
//   wen_a    : write enable
//   ack      : one-hot, bit i high in the cycle requester i's word is written
//   owner    : current grant holder index
//   busy     : high while a grant is active
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int MAX_BURST = 4,
    localparam int OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_a,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      full,
    output logic [DATA_W-1:0]         din_a,
    output logic                      wen_a,
    output logic [NUM_REQ-1:0]        ack,
    output logic [OWN_W-1:0]          owner,
    output logic                      busy
);

    arb_state_t       state;
    logic [OWN_W-1:0] owner_q;
    logic [OWN_W-1:0] rr_ptr;
    logic [3:0]       burst_cnt;

    logic [OWN_W-1:0] owner_inc;
    logic [OWN_W-1:0] ptr_sel;
    logic [OWN_W-1:0] pick_idx;
    logic             pick_valid;
    logic             in_burst;
    logic             req_own;
    logic             at_limit;
    logic             wr;
    logic             do_exit;

    assign owner_inc = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
    assign in_burst  = (state == ARB_BURST);
    assign req_own   = req[owner_q];

    // The burst counter reaching MAX_BURST records that the last allowed word
    // went out; that cycle carries no write and performs the handoff, which
    // gives the single bubble between grants.
    assign at_limit  = (burst_cnt == 4'(MAX_BURST));
    assign wr        = in_burst & req_own & ~full & ~at_limit;
    assign do_exit   = in_burst & (~req_own | at_limit);

    // One picker serves both paths: from rr_ptr when idle, from owner+1 on a
    // handoff (the rotated pointer is not registered yet in that cycle).
    assign ptr_sel   = in_burst ? owner_inc : rr_ptr;

    rr_pick_comb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (OWN_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_sel),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Outputs are gated by state so they drop as soon as reset asserts.
    assign wen_a = wr;
    assign din_a = wr ? req_data[owner_q*DATA_W +: DATA_W] : '0;
    assign ack   = wr ? (NUM_REQ'(1) << owner_q) : '0;
    assign owner = owner_q;
    assign busy  = in_burst;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            owner_q   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner_q   <= pick_idx;
                        burst_cnt <= '0;
                        state     <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (do_exit) begin
                        rr_ptr <= owner_inc;
                        if (pick_valid) begin
                            owner_q   <= pick_idx;
                            burst_cnt <= '0;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end else if (wr) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (4 requesters, 16-bit, bursts of 4).
// A behavioural reference tracks who holds the port, how many words the
// holder has written and where the round-robin scan starts.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic            clk_a;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            full;
    logic [DW-1:0]   din_a;
    logic            wen_a;
    logic [N-1:0]    ack;
    logic [1:0]      owner;
    logic            busy;
    logic [23:0]     obs;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk_a    (clk_a),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .din_a    (din_a),
        .wen_a    (wen_a),
        .ack      (ack),
        .owner    (owner),
        .busy     (busy)
    );

    assign obs = {wen_a, ack, owner, busy, din_a};

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    // ---------------- reference model ----------------
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_words;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_ptr   <= 0;
            m_words <= 0;
        end else if (!m_busy) begin
            if (req != 0) begin
                m_busy  <= 1'b1;
                m_owner <= pick(req, m_ptr);
                m_words <= 0;
            end
        end else if (!req[m_owner] || m_words >= MB) begin
            m_ptr <= (m_owner + 1) % N;
            if (req != 0) begin
                m_owner <= pick(req, (m_owner + 1) % N);
                m_words <= 0;
            end else begin
                m_busy <= 1'b0;
            end
        end else if (!full) begin
            m_words <= m_words + 1;
        end
    end

    function automatic logic [23:0] exp_vec();
        logic          w;
        logic [N-1:0]  a;
        logic [DW-1:0] d;
        w = m_busy && req[m_owner] && !full && (m_words < MB);
        a = w ? (4'(1) << m_owner) : 4'b0;
        d = w ? req_data[m_owner*DW +: DW] : '0;
        return {w, a, 2'(m_owner), m_busy, d};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        full  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 4'b1111;
        full     = 1'b0;
        req_data = {$urandom, $urandom};
        tick();
        tick();
        @(negedge clk_a);
        checks++;
        if ({wen_a, ack, busy, owner} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=00", {wen_a, ack, busy, owner});
        end
        tick();
        rst_n = 1'b1;
        req   = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_a);
            checks++;
            if (obs !== 24'h0) begin
                errors++;
                $display("FAIL idle_quiet c=%0d got=%h exp=000000", c, obs);
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL idle_model c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_single_burst();
        logic exp_w;
        apply_reset();
        req_data         = {$urandom, $urandom};
        req_data[DW+:DW] = 16'hA5A5;
        req              = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_a);
            exp_w = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
            checks++;
            if (wen_a !== exp_w) begin
                errors++;
                $display("FAIL single_wen c=%0d got=%b exp=%b", c, wen_a, exp_w);
            end
            if (exp_w) begin
                checks++;
                if (din_a !== 16'hA5A5 || ack !== 4'b0010 || owner !== 2'd1) begin
                    errors++;
                    $display("FAIL single_word c=%0d got din=%h ack=%b owner=%0d exp din=a5a5 ack=0010 owner=1",
                             c, din_a, ack, owner);
                end
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_model c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int   acks[N];
        int   grants[$];
        int   exp_order[5] = '{0, 1, 2, 3, 0};
        logic prev_w;
        apply_reset();
        req    = 4'b1111;
        prev_w = 1'b0;
        for (int i = 0; i < N; i++) acks[i] = 0;
        for (int c = 0; c < 25; c++) begin
            req_data = {$urandom, $urandom};
            @(negedge clk_a);
            checks++;
            if (wen_a !== (c % 5 != 0)) begin
                errors++;
                $display("FAIL rr_bubble c=%0d got wen=%b exp=%b", c, wen_a, (c % 5 != 0));
            end
            if (c < 20) begin
                for (int i = 0; i < N; i++) if (ack[i] === 1'b1) acks[i]++;
            end
            if (wen_a === 1'b1 && prev_w !== 1'b1) grants.push_back(int'(owner));
            prev_w = wen_a;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rr_model c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (acks[i] !== MB) begin
                errors++;
                $display("FAIL rr_ack_count req=%0d got=%0d exp=%0d", i, acks[i], MB);
            end
        end
        checks++;
        if (grants.size() !== 5) begin
            errors++;
            $display("FAIL rr_grant_count got=%0d exp=5", grants.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (grants[i] !== exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order slot=%0d got=%0d exp=%0d", i, grants[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        logic [DW-1:0] word;
        logic [DW-1:0] fifo_q[$];
        logic          exp_w;
        apply_reset();
        word                 = DW'($urandom);
        req_data             = {$urandom, $urandom};
        req_data[2*DW +: DW] = word;
        req                  = 4'b0100;
        for (int c = 0; c < 11; c++) begin
            full = (c >= 3 && c <= 7);
            @(negedge clk_a);
            exp_w = (c == 1 || c == 2 || c == 8 || c == 9);
            checks++;
            if (wen_a !== exp_w) begin
                errors++;
                $display("FAIL stall_wen c=%0d got=%b exp=%b", c, wen_a, exp_w);
            end
            checks++;
            if (wen_a === 1'b1 && full) begin
                errors++;
                $display("FAIL stall_write_while_full c=%0d got wen=1 exp wen=0", c);
            end
            if (c >= 1 && c <= 9) begin
                checks++;
                if (owner !== 2'd2) begin
                    errors++;
                    $display("FAIL stall_owner c=%0d got=%0d exp=2", c, owner);
                end
            end
            if (wen_a === 1'b1) fifo_q.push_back(din_a);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stall_model c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
        full = 1'b0;
        checks++;
        if (fifo_q.size() !== 4) begin
            errors++;
            $display("FAIL stall_fifo_count got=%0d exp=4", fifo_q.size());
        end
        foreach (fifo_q[i]) begin
            checks++;
            if (fifo_q[i] !== word) begin
                errors++;
                $display("FAIL stall_fifo_data idx=%0d got=%h exp=%h", i, fifo_q[i], word);
            end
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        req_data = {$urandom, $urandom};
        req      = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req[0] = 1'b0;
            @(negedge clk_a);
            if (c == 1) begin
                checks++;
                if ({wen_a, ack, owner} !== {1'b1, 4'b0001, 2'd0}) begin
                    errors++;
                    $display("FAIL withdraw_first got wen=%b ack=%b owner=%0d exp wen=1 ack=0001 owner=0",
                             wen_a, ack, owner);
                end
            end else if (c == 2) begin
                checks++;
                if ({wen_a, busy, owner} !== {1'b0, 1'b1, 2'd0}) begin
                    errors++;
                    $display("FAIL withdraw_exit got wen=%b busy=%b owner=%0d exp wen=0 busy=1 owner=0",
                             wen_a, busy, owner);
                end
            end else if (c == 3) begin
                checks++;
                if ({wen_a, ack, owner} !== {1'b1, 4'b1000, 2'd3}) begin
                    errors++;
                    $display("FAIL withdraw_handoff got wen=%b ack=%b owner=%0d exp wen=1 ack=1000 owner=3",
                             wen_a, ack, owner);
                end
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL withdraw_model c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        req_data = {$urandom, $urandom};
        req      = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_a);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_model c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
        checks++;
        if (wen_a !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_write got wen=%b exp=1", wen_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wen_a, ack, busy} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_async got wen=%b ack=%b busy=%b exp all 0", wen_a, ack, busy);
        end
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_a);
            if (c == 1) begin
                checks++;
                if ({wen_a, ack, owner} !== {1'b1, 4'b0001, 2'd0}) begin
                    errors++;
                    $display("FAIL midrst_restart got wen=%b ack=%b owner=%0d exp wen=1 ack=0001 owner=0",
                             wen_a, ack, owner);
                end
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_after c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            full     = ($urandom_range(3) == 0);
            req_data = {$urandom, $urandom};
            @(negedge clk_a);
            checks++;
            if (wen_a === 1'b1 && full) begin
                errors++;
                $display("FAIL rnd_write_while_full c=%0d got wen=1 exp wen=0", c);
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rnd_model c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
        req  = '0;
        full = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        full     = 1'b0;
        req_data = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_withdraw();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
